// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage ahead of the ALU.
// Reads regfile, registers ALU controls behind valid/ready.
module decode_issue #(
   parameter int WIDTH = 16,
   parameter int RADDR = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [RADDR-1:0] rs_addr,
   output logic [RADDR-1:0] rt_addr,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [4:0]       alu_opcode,
   output logic [1:0]       alu_funct,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             wr_en,
   output logic [RADDR-1:0] wr_reg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             halted,
   output logic [15:0]      issue_cnt
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t state, state_nx;

   logic [4:0]       opc;
   logic             accept;
   logic [WIDTH-1:0] d_a;
   logic [WIDTH-1:0] d_b;
   logic             d_we;
   logic [RADDR-1:0] d_wr;

   assign opc     = instr[15:11];
   assign rs_addr = instr[10:8];
   assign rt_addr = instr[7:5];
   assign accept  = instr_valid && instr_ready;

   // state register; HALTED is sticky until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nx;
   end

   // leave RUN once a HALT has been accepted
   always_comb begin
      state_nx = state;
      if (state == RUN && accept && opc == 5'b00000)
         state_nx = HALTED;
   end

   // handshake outputs derived from state and issue occupancy
   always_comb begin
      halted      = (state == HALTED);
      instr_ready = (state == RUN) && (!out_valid || out_ready);
   end

   // operand B and writeback selection by opcode class
   always_comb begin
      d_a  = rs_data;
      d_b  = '0;
      d_we = 1'b0;
      d_wr = '0;
      unique case (1'b1)
         (opc[4:1] == 4'b0100): begin
            d_b  = {{(WIDTH-5){instr[4]}}, instr[4:0]};
            d_wr = instr[7:5];
            d_we = 1'b1;
         end
         (opc[4:1] == 4'b0101): begin
            d_b  = {{(WIDTH-5){1'b0}}, instr[4:0]};
            d_wr = instr[7:5];
            d_we = 1'b1;
         end
         (opc[4:2] == 3'b101): begin
            d_b  = {{(WIDTH-4){1'b0}}, instr[3:0]};
            d_wr = instr[7:5];
            d_we = 1'b1;
         end
         (opc[4:1] == 4'b1101),
         (opc[4:2] == 3'b111): begin
            d_b  = rt_data;
            d_wr = instr[4:2];
            d_we = 1'b1;
         end
         (opc == 5'b11001): begin
            d_wr = instr[4:2];
            d_we = 1'b1;
         end
         (opc == 5'b11000): begin
            d_a  = '0;
            d_b  = {{(WIDTH-8){instr[7]}}, instr[7:0]};
            d_wr = instr[10:8];
            d_we = 1'b1;
         end
         (opc == 5'b10010): begin
            d_b  = {{(WIDTH-8){1'b0}}, instr[7:0]};
            d_wr = instr[10:8];
            d_we = 1'b1;
         end
         (opc == 5'b10001): begin
            d_b  = {{(WIDTH-5){instr[4]}}, instr[4:0]};
            d_wr = instr[7:5];
            d_we = 1'b1;
         end
         (opc == 5'b10000): begin
            d_b  = {{(WIDTH-5){instr[4]}}, instr[4:0]};
         end
         (opc == 5'b10011): begin
            d_b  = {{(WIDTH-5){instr[4]}}, instr[4:0]};
            d_wr = instr[10:8];
            d_we = 1'b1;
         end
         (opc[4:1] == 4'b0011): begin
            d_wr = '1;
            d_we = 1'b1;
         end
         default: ;
      endcase
   end

   // issue register: load on accept, otherwise empty on drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         alu_opcode <= '0;
         alu_funct  <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         wr_en      <= 1'b0;
         wr_reg     <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         alu_opcode <= opc;
         alu_funct  <= instr[1:0];
         alu_a      <= d_a;
         alu_b      <= d_b;
         wr_en      <= d_we;
         wr_reg     <= d_wr;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // count every accepted instruction, wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      issue_cnt <= '0;
      else if (accept) issue_cnt <= issue_cnt + 16'd1;
   end

endmodule
